// File: rtl/segmented_crc_engine.sv
// segmented_crc_engine
// Multi-cycle CRC engine: each accepted beat is folded into the CRC STRIDE
// bits per clock, MSB first. The final frame CRC is held on a registered,
// back-pressured output until the consumer takes it.
module segmented_crc_engine #(
    parameter int                 CRC_W  = 16,
    parameter int                 DW     = 16,
    parameter int                 STRIDE = 4,
    parameter logic [CRC_W-1:0]   POLY   = 16'h1021,
    parameter logic [CRC_W-1:0]   INIT   = 16'hFFFF,
    parameter logic [CRC_W-1:0]   XOROUT = 16'h0000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DW-1:0]     i_in_data,
    input  logic              i_in_first,
    input  logic              i_in_last,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [CRC_W-1:0]  o_out_crc,
    output logic              o_busy
);

    // Number of segments per beat and the counter width that spans them.
    localparam int S     = DW / STRIDE;
    localparam int CNT_W = (S > 1) ? $clog2(S) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_HOLD
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CRC_W-1:0]    r_crc;
    logic [DW-1:0]       r_shift;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_last;
    logic                r_out_valid;
    logic [CRC_W-1:0]    r_out_crc;

    logic                w_accept;
    logic                w_last_seg;
    logic                w_fb;
    logic [CRC_W-1:0]    w_crc_next;

    assign w_accept   = i_in_valid && (r_state == ST_IDLE);
    assign w_last_seg = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(S - 1));

    assign o_in_ready  = (r_state == ST_IDLE);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_out_valid = r_out_valid;
    assign o_out_crc   = r_out_crc;

    // Fold the top STRIDE bits of the data register into the CRC, MSB first.
    always_comb begin
        w_crc_next = r_crc;
        w_fb       = 1'b0;
        for (int i = 0; i < STRIDE; i++) begin
            w_fb       = w_crc_next[CRC_W-1] ^ r_shift[DW-1-i];
            w_crc_next = {w_crc_next[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
        end
    end

    // Next-state logic for the accept / shift / hold sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_in_valid)  w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_last_seg)  w_state_next = r_last ? ST_HOLD : ST_IDLE;
            ST_HOLD:  if (i_out_ready) w_state_next = ST_IDLE;
            default:                   w_state_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: beat capture, per-segment CRC update, result register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_crc       <= INIT;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_last      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_crc   <= '0;
        end else begin
            if (w_accept) begin
                r_shift <= i_in_data;
                r_last  <= i_in_last;
                r_cnt   <= '0;
                // A new frame start discards whatever partial CRC was pending.
                if (i_in_first) begin
                    r_crc <= INIT;
                end
            end
            if (r_state == ST_SHIFT) begin
                r_crc   <= w_crc_next;
                r_shift <= r_shift << STRIDE;
                if (w_last_seg) begin
                    r_cnt <= '0;
                    if (r_last) begin
                        r_out_crc   <= w_crc_next ^ XOROUT;
                        r_out_valid <= 1'b1;
                        // Reseed so a following frame works without a first flag.
                        r_crc       <= INIT;
                    end
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if ((r_state == ST_HOLD) && i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
